morse_encode_word: RTL and testbench
====================================

# morse_encode_word

Transmit-side counterpart of the Morse word decoder. It accepts a word buffer of `MAX_CHARS` character codes in the same packed format the decoder produces, with the newest character at bits [`CHAR_W`-1:0] and unused slots filled with `CHAR_CODE_SPACE`. It emits the word as an on/off key signal with standard Morse unit timing, paced by the shared `ce` unit tick. Character-to-pattern translation is done by an external combinational lookup, whose pattern format matches the decoder's `len`/`dits_dahs` inputs.

## Interface
- No parameters; widths come from defines.vh: `CHAR_W`, `MAX_CHARS`, `MAX_MORSE_LEN`, `MORSE_LEN_W`, `CHAR_CODE_SPACE`.
- clk  input  1  system clock, single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- ce  input  1  Morse unit tick; all key timing counts ce-qualified clk edges.
- start  input  1  request to send `word`; accepted on any clk edge where busy=0, independent of ce.
- word  input  `CHAR_W*MAX_CHARS`  packed characters; slot 0 is at the LSBs and is sent last.
- busy  output  1  high from the edge after acceptance until done.
- key  output  1  Morse output; 1 = tone on.
- done  output  1  one-clk pulse when transmission, including the trailing word gap, completes.
- error  output  1  sticky; set when an unknown character is met; cleared on the next accepted start.
- lookup_char  output  `CHAR_W`  character currently selected for lookup (registered).
- lookup_len  input  `MORSE_LEN_W`  element count for lookup_char, returned combinationally; 0 means unknown.
- lookup_dits_dahs  input  `MAX_MORSE_LEN`  pattern for lookup_char: bit 1 = dah, 0 = dit. The first element is at bit lookup_len-1 and the last at bit 0.

## Operation
- Reset values: busy=0, key=0, done=0, error=0, lookup_char=`CHAR_CODE_SPACE`, FSM=IDLE.
- On accept, the block latches `word`, clears error, and sets the character index to `MAX_CHARS`-1.
- Leading slots (highest indices) equal to `CHAR_CODE_SPACE` are skipped.
- Characters are then sent from that index down to 0.
- States:
  - IDLE: waits for start.
  - SEEK: selects the next character.
  - MARK: key=1.
  - EGAP: intra-character gap.
  - CGAP: inter-character gap.
  - WGAP: word gap.
- Unit durations, counted in ce ticks:
  - dit mark = 1 unit; dah mark = 3 units.
  - Gap between elements of one character = 1 unit.
  - Gap between characters = 3 units.
  - Word gap = 7 units.
- A run of one or more SPACE or unknown characters between two sent characters produces a single 7-unit gap in place of the 3-unit gap.
- Unknown character (lookup_len=0 while lookup_char is not SPACE): error is set and the character is sent as nothing, i.e. treated as SPACE for gap purposes.
- After character 0, or after the last known character, the block always sends a 7-unit WGAP with key=0, then pulses done.
- All-SPACE word, or a word made only of unknown characters: no mark is sent, WGAP is skipped, and done pulses at the first ce after acceptance.
- The lookup result is sampled in SEEK. The pattern and length are copied into internal registers, so lookup_char may advance during gaps.
- start while busy=1 is ignored. word may change after acceptance.
- Reset mid-transmission: key drops immediately (asynchronously), the FSM returns to IDLE, and no done pulse is produced.

## Timing
- Cycle A (start=1, busy=0): latch the word; busy=1 from A+1.
- The key rises on the first ce edge after A. Zero-cycle scan: skipping any number of leading spaces takes no extra ce ticks; SEEK may use plain clk cycles between ce ticks.
- key transitions occur only on ce-qualified edges. Each unit is exactly one ce period, with no cycle slip between consecutive elements.
- done=1 for exactly one clk on the edge that completes the last WGAP unit; busy=0 on the same edge.
- A start sampled in that same cycle is ignored; start is accepted from the next cycle onward.
- ce held high continuously gives a 1-clk unit; the block must handle this with no added bubble.
- Internal counters: the unit counter is at least 3 bits (max 7). The element index is `MORSE_LEN_W` bits and runs from lookup_len-1 down to 0 with no wrap.

## Test plan
The bench uses a lookup stub: code 1 → len 1, bits 0 ('E'); code 2 → len 1, bits 1 ('T'); code 3 → len 2, bits 01 ('A'); code 7 → len 0 (unknown). ce is high every 4th clk.

- word = SPACEs with slots 1,0 = 3,2 ("AT") -> key per ce unit: 1,0,1,1,1,0,0,0,1,1,1, then 7 zeros. done once and busy=0 after 18 units; error=0.
- Slots 2,1,0 = 1,SPACE,1 -> key sequence 1, seven 0s, 1, seven 0s, then done.
- Slots 1,0 = 7,1 -> error=1 and only 'E' is sent (1, then 7 zeros). A new start with "E" clears error.
- All-SPACE word -> key stays 0; done pulses at the first ce after accept.
- Assert rst during the dah of 'A' -> key=0, busy=0 asynchronously, no done. A fresh start works normally.
- ce tied high with "T" -> key high for 3 clks, low for 7, done in the 10th clk; a start during busy has no effect.

Source files
------------

// File: rtl/morse_encode_word.sv
// morse_encode_word: sends a packed word buffer as a Morse on/off key.
// Leading spaces are skipped combinationally on accept, so the first mark
// starts on the first ce tick. While a character is keyed, the next one is
// prefetched through the external lookup, so gaps need no extra ticks.

`ifndef CHAR_W
`define CHAR_W 6
`endif
`ifndef MAX_CHARS
`define MAX_CHARS 4
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 6
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif
`ifndef CHAR_CODE_SPACE
`define CHAR_CODE_SPACE 6'd36
`endif

module morse_encode_word (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic                           start,
  input  logic [`CHAR_W*`MAX_CHARS-1:0]  word,
  output logic                           busy,
  output logic                           key,
  output logic                           done,
  output logic                           error,
  output logic [`CHAR_W-1:0]             lookup_char,
  input  logic [`MORSE_LEN_W-1:0]        lookup_len,
  input  logic [`MAX_MORSE_LEN-1:0]      lookup_dits_dahs
);

  localparam int CW = `CHAR_W;
  localparam int NC = `MAX_CHARS;
  localparam int LW = `MORSE_LEN_W;
  localparam int PW = `MAX_MORSE_LEN;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [CW-1:0] SPACE = `CHAR_CODE_SPACE;

  typedef enum logic [2:0] {IDLE, SEEK, MARK, EGAP, CGAP, WGAP} state_t;

  state_t             state_q;
  logic [CW*NC-1:0]   word_q;
  logic [IW-1:0]      idx_q;        // slot of the character in lookup_char_q
  logic               cand_q;       // lookup_char_q holds a real (non-space) slot
  logic [CW-1:0]      lookup_char_q;
  logic [PW-1:0]      pat_q;
  logic [LW-1:0]      el_q;
  logic [2:0]         cnt_q;        // ce ticks left in the current unit run
  logic [PW-1:0]      nxt_pat_q;
  logic [LW-1:0]      nxt_len_q;
  logic               nxt_ok_q;     // prefetched known character waiting
  logic               nxt_sep_q;    // space/unknown lies before the prefetched char
  logic               sep_q;        // space/unknown seen since the last prefetch
  logic               busy_q;
  logic               key_q;
  logic               done_q;
  logic               error_q;

  function automatic logic [CW-1:0] char_at(input logic [CW*NC-1:0] w,
                                            input logic [IW-1:0] i);
    return w[int'(i)*CW +: CW];
  endfunction

  // {found, index} of the highest non-space slot strictly below limit
  function automatic logic [IW:0] scan_below(input logic [CW*NC-1:0] w,
                                             input logic [IW:0] limit);
    logic [IW:0] r;
    r = '0;
    for (int j = 0; j < NC; j++) begin
      if (j < int'(limit) && w[j*CW +: CW] != SPACE) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

  function automatic logic [2:0] unit_len(input logic dah);
    return dah ? 3'd3 : 3'd1;
  endfunction

  logic [IW:0]   top_scan;
  logic [IW:0]   adv_scan;
  logic          adv_found;
  logic          adv_skip;
  logic [IW-1:0] adv_idx;
  logic [CW-1:0] top_char;
  logic [CW-1:0] adv_char;
  logic          fetch_en;

  assign top_scan  = scan_below(word, (IW+1)'(NC));
  assign top_char  = top_scan[IW] ? char_at(word, top_scan[IW-1:0]) : SPACE;
  assign adv_scan  = scan_below(word_q, {1'b0, idx_q});
  assign adv_found = adv_scan[IW];
  assign adv_idx   = adv_scan[IW-1:0];
  assign adv_char  = adv_found ? char_at(word_q, adv_idx) : SPACE;
  // skipped spaces between the current slot and the next real one
  assign adv_skip  = adv_found && (adv_idx != idx_q - IW'(1));
  assign fetch_en  = (state_q inside {MARK, EGAP, CGAP, WGAP}) && cand_q && !nxt_ok_q;

  // Transmit FSM plus the lookup prefetch that runs alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      word_q        <= '0;
      idx_q         <= '0;
      cand_q        <= 1'b0;
      lookup_char_q <= SPACE;
      pat_q         <= '0;
      el_q          <= '0;
      cnt_q         <= '0;
      nxt_pat_q     <= '0;
      nxt_len_q     <= '0;
      nxt_ok_q      <= 1'b0;
      nxt_sep_q     <= 1'b0;
      sep_q         <= 1'b0;
      busy_q        <= 1'b0;
      key_q         <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Prefetch: resolve the next slot while the current character is keyed.
      if (fetch_en) begin
        if (lookup_len == '0) begin
          error_q <= 1'b1;
          sep_q   <= 1'b1;
        end else begin
          nxt_pat_q <= lookup_dits_dahs;
          nxt_len_q <= lookup_len;
          nxt_ok_q  <= 1'b1;
          nxt_sep_q <= sep_q;
          sep_q     <= adv_skip;
        end
        idx_q         <= adv_idx;
        cand_q        <= adv_found;
        lookup_char_q <= adv_char;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            word_q        <= word;
            error_q       <= 1'b0;
            busy_q        <= 1'b1;
            nxt_ok_q      <= 1'b0;
            sep_q         <= 1'b0;
            idx_q         <= top_scan[IW-1:0];
            cand_q        <= top_scan[IW];
            lookup_char_q <= top_char;
            state_q       <= SEEK;
          end
        end

        SEEK: begin
          if (cand_q && lookup_len == '0) begin
            // leading unknown: flag it and move on without keying anything
            error_q       <= 1'b1;
            idx_q         <= adv_idx;
            cand_q        <= adv_found;
            lookup_char_q <= adv_char;
            if (ce && !adv_found) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else if (ce) begin
            if (cand_q) begin
              pat_q         <= lookup_dits_dahs;
              el_q          <= lookup_len - LW'(1);
              cnt_q         <= unit_len(lookup_dits_dahs[lookup_len - LW'(1)]);
              key_q         <= 1'b1;
              state_q       <= MARK;
              sep_q         <= adv_skip;
              idx_q         <= adv_idx;
              cand_q        <= adv_found;
              lookup_char_q <= adv_char;
            end else begin
              // nothing sendable: no marks and no word gap
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end

        MARK: begin
          if (ce) begin
            if (cnt_q == 3'd1) begin
              key_q <= 1'b0;
              if (el_q == '0) begin
                cnt_q   <= 3'd3;
                state_q <= CGAP;
              end else begin
                el_q    <= el_q - LW'(1);
                cnt_q   <= 3'd1;
                state_q <= EGAP;
              end
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
        end

        EGAP: begin
          if (ce) begin
            key_q   <= 1'b1;
            cnt_q   <= unit_len(pat_q[el_q]);
            state_q <= MARK;
          end
        end

        // CGAP's three units are also the first three of any word gap;
        // WGAP supplies the remaining four.
        CGAP: begin
          if (ce) begin
            if (cnt_q == 3'd1) begin
              if (nxt_ok_q && !nxt_sep_q) begin
                pat_q    <= nxt_pat_q;
                el_q     <= nxt_len_q - LW'(1);
                cnt_q    <= unit_len(nxt_pat_q[nxt_len_q - LW'(1)]);
                key_q    <= 1'b1;
                nxt_ok_q <= 1'b0;
                state_q  <= MARK;
              end else begin
                cnt_q   <= 3'd4;
                state_q <= WGAP;
              end
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
        end

        WGAP: begin
          if (ce) begin
            if (cnt_q == 3'd1) begin
              if (nxt_ok_q) begin
                pat_q    <= nxt_pat_q;
                el_q     <= nxt_len_q - LW'(1);
                cnt_q    <= unit_len(nxt_pat_q[nxt_len_q - LW'(1)]);
                key_q    <= 1'b1;
                nxt_ok_q <= 1'b0;
                state_q  <= MARK;
              end else if (!cand_q) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign key         = key_q;
  assign done        = done_q;
  assign error       = error_q;
  assign lookup_char = lookup_char_q;

endmodule

// File: tb/tb_morse_encode_word.sv
// Directed bench for morse_encode_word with a four-entry lookup stub.

`ifndef CHAR_W
`define CHAR_W 6
`endif
`ifndef MAX_CHARS
`define MAX_CHARS 4
`endif
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 6
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif
`ifndef CHAR_CODE_SPACE
`define CHAR_CODE_SPACE 6'd36
`endif

module tb_morse_encode_word;
  localparam int CW = `CHAR_W;
  localparam int NC = `MAX_CHARS;
  localparam int LW = `MORSE_LEN_W;
  localparam int PW = `MAX_MORSE_LEN;
  localparam logic [CW-1:0] SP = `CHAR_CODE_SPACE;

  logic clk = 1'b0;
  logic rst, ce, start;
  logic [CW*NC-1:0] word;
  logic busy, key, done, error;
  logic [CW-1:0] lookup_char;
  logic [LW-1:0] lookup_len;
  logic [PW-1:0] lookup_dd;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ph = 0;
  logic ce_cont = 1'b0;
  logic ce_at_edge = 1'b0;

  always #5 clk = ~clk;

  morse_encode_word dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .word(word),
    .busy(busy), .key(key), .done(done), .error(error),
    .lookup_char(lookup_char), .lookup_len(lookup_len),
    .lookup_dits_dahs(lookup_dd)
  );

  // Lookup stub: 1='E', 2='T', 3='A', everything else unknown
  always_comb begin
    lookup_len = '0;
    lookup_dd  = '0;
    case (lookup_char)
      6'd1: begin lookup_len = 3'd1; lookup_dd = 6'b000000; end
      6'd2: begin lookup_len = 3'd1; lookup_dd = 6'b000001; end
      6'd3: begin lookup_len = 3'd2; lookup_dd = 6'b000001; end
      default: ;
    endcase
  end

  function automatic logic [CW*NC-1:0] mkw(input logic [CW-1:0] c3, input logic [CW-1:0] c2,
                                           input logic [CW-1:0] c1, input logic [CW-1:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clk; ce for the following edge is set up afterwards
  task automatic tick();
    ce_at_edge = ce;
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
    if (ce_cont) ce = 1'b1;
    else begin
      ph = (ph + 1) % 4;
      ce = (ph == 3);
    end
  endtask

  task automatic next_unit();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ce_at_edge && n < 16);
  endtask

  task automatic chk_keys(input string tag, input logic [31:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      next_unit();
      chk($sformatf("%s_u%0d", tag, n - i), 32'(key), 32'(pat[i]));
    end
  endtask

  task automatic send(input string tag, input logic [CW*NC-1:0] w,
                      input logic [31:0] pat, input int n);
    int d0;
    word = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    word = '1;
    d0 = done_cnt;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_errclr"}, 32'(error), 32'd0);
    chk_keys(tag, pat, n);
    chk({tag, "_nodone_early"}, 32'(done_cnt), 32'(d0));
    next_unit();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_keyoff"}, 32'(key), 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    ce = 1'b0;
    word = mkw(SP, SP, SP, SP);
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_key", 32'(key), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_lchar", 32'(lookup_char), 32'(SP));
    rst = 1'b0;
    tick();

    // "AT": .- then 3-unit gap, - then word gap
    send("at", mkw(SP, SP, 6'd3, 6'd2), 32'b101110001110000000, 18);
    chk("at_err", 32'(error), 32'd0);

    // E SPACE E: the space becomes a 7-unit gap
    send("ese", mkw(SP, 6'd1, SP, 6'd1), 32'b1000000010000000, 16);

    // unknown then E: only E is keyed, error sticks
    send("unk", mkw(SP, SP, 6'd7, 6'd1), 32'b10000000, 8);
    chk("unk_err", 32'(error), 32'd1);
    send("eclr", mkw(SP, SP, SP, 6'd1), 32'b10000000, 8);
    chk("eclr_err", 32'(error), 32'd0);

    // all spaces: done at the first ce after accept, key never rises
    word = mkw(SP, SP, SP, SP);
    start = 1'b1;
    tick();
    start = 1'b0;
    d0 = done_cnt;
    chk("sp_busy", 32'(busy), 32'd1);
    next_unit();
    chk("sp_done", 32'(done), 32'd1);
    chk("sp_key", 32'(key), 32'd0);
    chk("sp_busy0", 32'(busy), 32'd0);
    chk("sp_donecnt", 32'(done_cnt), 32'(d0 + 1));

    // reset during the dah of 'A'
    word = mkw(SP, SP, SP, 6'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_keys("rsta", 32'b101, 3);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("rsta_key_async", 32'(key), 32'd0);
    chk("rsta_busy_async", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    repeat (40) tick();
    chk("rsta_nodone", 32'(done_cnt), 32'(d0));
    chk("rsta_idle_key", 32'(key), 32'd0);
    send("post_rst", mkw(SP, SP, SP, 6'd2), 32'b1110000000, 10);

    // ce held high: 1-clk units, start while busy ignored
    ce_cont = 1'b1;
    ce = 1'b1;
    tick();
    word = mkw(SP, SP, SP, 6'd2);
    start = 1'b1;
    tick();
    word = mkw(SP, SP, SP, 6'd1);
    chk("cont_busy", 32'(busy), 32'd1);
    chk_keys("cont_a", 32'b111, 3);
    start = 1'b0;
    chk_keys("cont_b", 32'b0, 7);
    start = 1'b1;
    d0 = done_cnt;
    next_unit();
    chk("cont_done", 32'(done), 32'd1);
    chk("cont_start_ignored", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    chk("cont_reaccept", 32'(busy), 32'd1);
    chk_keys("cont_e", 32'b10000000, 8);
    next_unit();
    chk("cont_e_done", 32'(done), 32'd1);
    chk("cont_donecnt", 32'(done_cnt), 32'(d0 + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
